// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - ASCII constants and FSM encoding shared by the hex line printer
package uart_pkg;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_A  = 8'h41;
  localparam logic [7:0] CHAR_X  = 8'h78;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// rtl/hex_nibble_to_ascii.sv - one hex nibble to its uppercase ASCII digit
module hex_nibble_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = CHAR_0 + {4'b0000, nibble};
    else                ascii = CHAR_A + {4'b0000, nibble} - 8'd10;
  end

endmodule

// File: rtl/uart_hex_printer.sv
// rtl/uart_hex_printer.sv - streams a latched value as "0x<hex>\r\n" into a uart_tx byte port
module uart_hex_printer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter bit PREFIX_EN  = 1'b1,
  parameter bit NEWLINE_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  print_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_data_valid_o,
  input  logic                  tx_data_ready_i
);

  localparam int NDIG    = DATA_WIDTH / 4;
  localparam int PFX_LEN = PREFIX_EN ? 2 : 0;
  localparam int N       = PFX_LEN + NDIG + (NEWLINE_EN ? 2 : 0);
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [31:0] DIG_END = 32'(PFX_LEN + NDIG);
  localparam logic [31:0] LAST    = 32'(N - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic [DATA_WIDTH-1:0]   src;
  logic [31:0]             pos;
  logic [31:0]             digit;
  logic [3:0]              nibble;
  logic [7:0]              digit_char;
  logic [7:0]              next_char;
  logic                    accept;
  logic                    advance;
  logic                    finish;

  // In IDLE the mux looks at value_i directly so char[0] is ready on the accepting edge.
  assign src   = (state_q == IDLE) ? value_i : hold_q;
  assign pos   = (state_q == IDLE) ? 32'd0 : 32'(idx_q);
  assign digit = pos - 32'(PFX_LEN);

  always_comb begin
    nibble = 4'h0;
    for (int k = 0; k < NDIG; k++) begin
      if (digit == 32'(k)) nibble = src[DATA_WIDTH-1-4*k -: 4];
    end
  end

  hex_nibble_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (digit_char)
  );

  always_comb begin
    if (PREFIX_EN && pos == 32'd0)      next_char = CHAR_0;
    else if (PREFIX_EN && pos == 32'd1) next_char = CHAR_X;
    else if (pos < DIG_END)             next_char = digit_char;
    else if (pos == DIG_END)            next_char = CHAR_CR;
    else                                next_char = CHAR_LF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (print_i) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_data_ready_i) begin
          if (32'(idx_q) == LAST) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP:     state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o          = (state_q != IDLE);
  assign tx_data_valid_o = (state_q == SEND);

  // The character register only loads on entry to SEND, so data holds under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      hold_q    <= '0;
      tx_data_o <= 8'h00;
      done_o    <= 1'b0;
    end else begin
      done_o <= finish;
      if (accept) begin
        hold_q <= value_i;
        idx_q  <= '0;
      end else if (advance) begin
        idx_q <= idx_q + 1'b1;
      end
      if (accept || state_q == GAP) tx_data_o <= next_char;
    end
  end

endmodule

// File: tb/tb_uart_hex_printer.sv
// tb/tb_uart_hex_printer.sv - self-checking bench for uart_hex_printer
module tb_uart_hex_printer;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] value;
  logic        print, ready, busy, done, txv;
  logic [7:0]  txd;
  logic [7:0]  s_value, s_txd;
  logic        s_print, s_ready, s_busy, s_done, s_txv;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  byte_q_t     got_q;
  byte_q_t     s_q;
  int          done_q [$];
  int          stab_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_txd = 8'h00;

  always #5 clk = ~clk;

  uart_hex_printer dut (
    .clk_i(clk), .rst_i(rst), .value_i(value), .print_i(print),
    .busy_o(busy), .done_o(done), .tx_data_o(txd),
    .tx_data_valid_o(txv), .tx_data_ready_i(ready)
  );

  uart_hex_printer #(.DATA_WIDTH(8), .PREFIX_EN(1'b0), .NEWLINE_EN(1'b0)) dut_small (
    .clk_i(clk), .rst_i(rst), .value_i(s_value), .print_i(s_print),
    .busy_o(s_busy), .done_o(s_done), .tx_data_o(s_txd),
    .tx_data_valid_o(s_txv), .tx_data_ready_i(s_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (txv && ready) got_q.push_back(txd);
    if (s_txv && s_ready) s_q.push_back(s_txd);
    if (done) done_q.push_back(cyc);
    if (prev_stall && txv && (txd !== prev_txd)) stab_cnt <= stab_cnt + 1;
    prev_stall <= txv && !ready;
    prev_txd   <= txd;
  end

  // Expected line built directly from the textual rules: "0x", digits MSB first, CR LF.
  function automatic byte_q_t model(input logic [63:0] v, input int ndig, input bit pfx, input bit nl);
    byte_q_t q;
    int n;
    if (pfx) begin q.push_back(8'h30); q.push_back(8'h78); end
    for (int d = ndig - 1; d >= 0; d--) begin
      n = int'((v >> (4 * d)) & 64'hF);
      q.push_back(n < 10 ? 8'(48 + n) : 8'(55 + n));
    end
    if (nl) begin q.push_back(8'h0D); q.push_back(8'h0A); end
    return q;
  endfunction

  function automatic byte_q_t since(input byte_q_t q, input int b);
    byte_q_t r;
    for (int i = b; i < q.size(); i++) r.push_back(q[i]);
    return r;
  endfunction

  function automatic bit q_equal(input byte_q_t a, input byte_q_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt(input byte_q_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic pulse_print(input logic [63:0] v);
    value = v;
    print = 1'b1;
    @(posedge clk); #1;
    print = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int dc);
    ok = 1'b0;
    dc = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; dc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; print = 1'b0; ready = 1'b0; value = '0;
    s_print = 1'b0; s_ready = 1'b0; s_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (txv !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", txv); end
    checks++; if (txd !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (s_txv !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL reset_small got=%b%b exp=00", s_txv, s_busy); end
    @(posedge clk); #1 rst = 1'b0;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (txv !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_print got=%b%b exp=00", txv, busy); end
  endtask

  task automatic test_full_line();
    byte_q_t exp, got;
    int b0, d0, fv, dc, lat;
    bit ok;
    ready = 1'b1;
    exp = model(64'h0123456789ABCDEF, 16, 1'b1, 1'b1);
    b0 = got_q.size(); d0 = done_q.size();
    pulse_print(64'h0123456789ABCDEF);
    checks++; if (busy !== 1'b1 || txv !== 1'b1 || txd !== 8'h30)
      begin errors++; $display("FAIL full_latency got busy=%b valid=%b data=%h exp 1 1 30", busy, txv, txd); end
    @(negedge clk); fv = cyc;
    wait_done(200, ok, dc);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_at_done got=%b exp=0", busy); end
    lat = ok ? dc - fv : -1;
    checks++; if (lat != 39) begin errors++; $display("FAIL full_done_latency got=%0d exp=39", lat); end
    repeat (5) @(posedge clk); #1;
    got = since(got_q, b0);
    checks++; if (!q_equal(got, exp)) begin errors++; $display("FAIL full_bytes got=%s exp=%s", fmt(got), fmt(exp)); end
    checks++; if (done_q.size() - d0 != 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", done_q.size() - d0); end
  endtask

  task automatic test_backpressure();
    byte_q_t exp, got;
    int b0, d0, s0;
    bit xfer;
    exp = model(64'h0123456789ABCDEF, 16, 1'b1, 1'b1);
    b0 = got_q.size(); d0 = done_q.size(); s0 = stab_cnt;
    ready = 1'b1;
    pulse_print(64'h0123456789ABCDEF);
    for (int c = 0; c < 3000 && done_q.size() == d0; c++) begin
      @(negedge clk); xfer = txv && ready;
      @(posedge clk); #1;
      if (xfer) begin
        ready = 1'b0;
        repeat (50) @(posedge clk);
        #1 ready = 1'b1;
      end
    end
    ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    got = since(got_q, b0);
    checks++; if (!q_equal(got, exp)) begin errors++; $display("FAIL bp_bytes got=%s exp=%s", fmt(got), fmt(exp)); end
    checks++; if (stab_cnt != s0) begin errors++; $display("FAIL bp_hold got=%0d changes exp=0", stab_cnt - s0); end
    checks++; if (done_q.size() - d0 != 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_q.size() - d0); end
  endtask

  task automatic test_busy_request();
    byte_q_t exp, got;
    int b0, d0, dc;
    bit ok;
    exp = model(64'h0123456789ABCDEF, 16, 1'b1, 1'b1);
    ready = 1'b1;
    b0 = got_q.size(); d0 = done_q.size();
    pulse_print(64'h0123456789ABCDEF);
    for (int c = 0; c < 100 && (got_q.size() - b0) < 2; c++) @(negedge clk);
    @(posedge clk); #1;
    value = '1; print = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    print = 1'b0;
    wait_done(200, ok, dc);
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout got=none exp=done"); end
    repeat (60) @(posedge clk); #1;
    got = since(got_q, b0);
    checks++; if (!q_equal(got, exp)) begin errors++; $display("FAIL busy_bytes got=%s exp=%s", fmt(got), fmt(exp)); end
    checks++; if (done_q.size() - d0 != 1 || busy !== 1'b0)
      begin errors++; $display("FAIL busy_single_done got=%0d busy=%b exp=1 busy=0", done_q.size() - d0, busy); end
  endtask

  task automatic test_reset_midline();
    byte_q_t exp, got;
    int b0, dc;
    bit ok;
    exp = model(64'h0, 16, 1'b1, 1'b1);
    ready = 1'b1;
    b0 = got_q.size();
    pulse_print(64'h0123456789ABCDEF);
    for (int c = 0; c < 100 && (got_q.size() - b0) < 5; c++) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    checks++; if (txv !== 1'b0 || busy !== 1'b0 || txd !== 8'h00)
      begin errors++; $display("FAIL midrst_outputs got valid=%b busy=%b data=%h exp 0 0 00", txv, busy, txd); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txv !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_resumed got=%b%b exp=00", txv, busy); end
    b0 = got_q.size();
    @(posedge clk); #1;
    pulse_print(64'h0);
    wait_done(200, ok, dc);
    repeat (3) @(posedge clk); #1;
    got = since(got_q, b0);
    checks++; if (!ok || !q_equal(got, exp)) begin errors++; $display("FAIL midrst_bytes got=%s exp=%s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_random();
    byte_q_t exp, got;
    logic [63:0] v;
    int b0, d0, s0;
    for (int it = 0; it < 4; it++) begin
      v = {$urandom, $urandom};
      exp = model(v, 16, 1'b1, 1'b1);
      b0 = got_q.size(); d0 = done_q.size(); s0 = stab_cnt;
      pulse_print(v);
      value = {$urandom, $urandom};
      for (int c = 0; c < 2000 && done_q.size() == d0; c++) begin
        ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      ready = 1'b1;
      repeat (4) @(posedge clk); #1;
      got = since(got_q, b0);
      checks++; if (!q_equal(got, exp)) begin errors++; $display("FAIL rand%0d_bytes got=%s exp=%s", it, fmt(got), fmt(exp)); end
      checks++; if (stab_cnt != s0) begin errors++; $display("FAIL rand%0d_hold got=%0d exp=0", it, stab_cnt - s0); end
      checks++; if (done_q.size() - d0 != 1) begin errors++; $display("FAIL rand%0d_done got=%0d exp=1", it, done_q.size() - d0); end
    end
  endtask

  task automatic test_param_variant();
    byte_q_t exp, got;
    int b0, fv, dc, lat;
    bit ok;
    exp = model(64'hA5, 2, 1'b0, 1'b0);
    s_ready = 1'b1;
    b0 = s_q.size();
    s_value = 8'hA5; s_print = 1'b1;
    @(posedge clk); #1 s_print = 1'b0;
    @(negedge clk); fv = cyc;
    ok = 1'b0; dc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_done === 1'b1) begin ok = 1'b1; dc = cyc; break; end
    end
    lat = ok ? dc - fv : -1;
    checks++; if (lat != 3) begin errors++; $display("FAIL small_done_latency got=%0d exp=3", lat); end
    repeat (3) @(posedge clk); #1;
    got = since(s_q, b0);
    checks++; if (!q_equal(got, exp)) begin errors++; $display("FAIL small_bytes got=%s exp=%s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_back_to_back();
    byte_q_t exp, e2, got;
    int b0, dc;
    bit ok, ok2;
    exp = model(64'h1, 16, 1'b1, 1'b1);
    e2  = model(64'h2, 16, 1'b1, 1'b1);
    foreach (e2[i]) exp.push_back(e2[i]);
    ready = 1'b1;
    b0 = got_q.size();
    value = 64'h1; print = 1'b1;
    @(posedge clk); #1;
    wait_done(200, ok, dc);
    value = 64'h2;
    @(posedge clk); #1 print = 1'b0;
    @(negedge clk);
    checks++; if (!ok || txv !== 1'b1 || busy !== 1'b1 || txd !== 8'h30)
      begin errors++; $display("FAIL b2b_restart got ok=%b valid=%b busy=%b data=%h exp 1 1 1 30", ok, txv, busy, txd); end
    wait_done(200, ok2, dc);
    repeat (4) @(posedge clk); #1;
    got = since(got_q, b0);
    checks++; if (!ok2 || !q_equal(got, exp)) begin errors++; $display("FAIL b2b_bytes got=%s exp=%s", fmt(got), fmt(exp)); end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_backpressure();
    test_busy_request();
    test_reset_midline();
    test_random();
    test_param_variant();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
